// File: rtl/prv32_alu_decode_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU function codes,
// immediate formats and the decoded control bundle.
package prv32_alu_decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_PASSB = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_SLT   = 4'b1101;
    localparam logic [3:0] ALU_SLTU  = 4'b1111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0]  alufn;
        logic        itype;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        a_pc;
        logic        b_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        branch;
        logic [2:0]  funct3;
        logic        illegal;
    } dec_ctrl_t;

    // OP and OP-IMM share the funct3 map; alt selects SUB/SRA.
    function automatic logic [3:0] op_alufn(input logic [2:0] f3, input logic alt);
        logic [3:0] fn;
        case (f3)
            3'b000:  fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  fn = ALU_SLL;
            3'b010:  fn = ALU_SLT;
            3'b011:  fn = ALU_SLTU;
            3'b100:  fn = ALU_XOR;
            3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  fn = ALU_OR;
            default: fn = ALU_AND;
        endcase
        return fn;
    endfunction

    function automatic logic [31:0] build_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/prv32_inst_decode.sv
// Combinational RV32I decoder: instruction word -> ALU control bundle.
module prv32_inst_decode
    import prv32_alu_decode_stage_pkg::*;
#(
    parameter bit FLAG_ILLEG = 1'b1
) (
    input  logic [31:0] inst_i,
    output dec_ctrl_t   ctrl_o
);

    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alufn;
    logic       itype;
    logic       a_pc;
    logic       b_imm;
    logic       branch;
    logic       wr;
    logic       legal;
    imm_fmt_e   fmt;

    assign opc    = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    always_comb begin
        alufn  = ALU_ADD;
        itype  = 1'b0;
        a_pc   = 1'b0;
        b_imm  = 1'b0;
        branch = 1'b0;
        wr     = 1'b0;
        legal  = 1'b1;
        fmt    = IMM_NONE;
        if (inst_i[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            case (opc)
                OPC_OP: begin
                    alufn = op_alufn(funct3, inst_i[30]);
                    wr    = 1'b1;
                    legal = (funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                end
                OPC_OPIMM: begin
                    // Only shifts look at inst[30]; ADDI with bit 30 set is still ADD.
                    alufn = op_alufn(funct3, (funct3 == 3'b101) ? inst_i[30] : 1'b0);
                    b_imm = 1'b1;
                    wr    = 1'b1;
                    fmt   = IMM_I;
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        itype = 1'b1;
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                end
                OPC_LUI: begin
                    alufn = ALU_PASSB;
                    b_imm = 1'b1;
                    wr    = 1'b1;
                    fmt   = IMM_U;
                end
                OPC_AUIPC: begin
                    a_pc  = 1'b1;
                    b_imm = 1'b1;
                    wr    = 1'b1;
                    fmt   = IMM_U;
                end
                OPC_LOAD: begin
                    b_imm = 1'b1;
                    wr    = 1'b1;
                    fmt   = IMM_I;
                end
                OPC_STORE: begin
                    b_imm = 1'b1;
                    fmt   = IMM_S;
                end
                OPC_BRANCH: begin
                    alufn  = ALU_SUB;
                    branch = 1'b1;
                    fmt    = IMM_B;
                    legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
                end
                OPC_JAL: begin
                    a_pc  = 1'b1;
                    b_imm = 1'b1;
                    wr    = 1'b1;
                    fmt   = IMM_J;
                end
                OPC_JALR: begin
                    b_imm = 1'b1;
                    wr    = 1'b1;
                    fmt   = IMM_I;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Illegal encodings collapse to an ADD that writes nothing.
    always_comb begin
        ctrl_o        = '0;
        ctrl_o.shamt  = inst_i[24:20];
        ctrl_o.rs1    = inst_i[19:15];
        ctrl_o.rs2    = inst_i[24:20];
        ctrl_o.rd     = inst_i[11:7];
        ctrl_o.funct3 = funct3;
        if (legal) begin
            ctrl_o.alufn  = alufn;
            ctrl_o.itype  = itype;
            ctrl_o.imm    = build_imm(inst_i, fmt);
            ctrl_o.a_pc   = a_pc;
            ctrl_o.b_imm  = b_imm;
            ctrl_o.branch = branch;
            ctrl_o.reg_wr = wr && (inst_i[11:7] != 5'd0);
        end else begin
            ctrl_o.illegal = FLAG_ILLEG;
        end
    end

endmodule

// File: rtl/prv32_alu_decode_stage.sv
// ID stage: decodes the fetched instruction and holds it in a single-entry
// valid/ready register in front of execute.
module prv32_alu_decode_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          FLAG_ILLEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alufn,
    output logic        out_itype,
    output logic [4:0]  out_shamt,
    output logic [31:0] out_imm,
    output logic        out_a_pc,
    output logic        out_b_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_reg_wr,
    output logic        out_branch,
    output logic [2:0]  out_funct3,
    output logic [31:0] out_pc,
    output logic        out_illegal
);
    import prv32_alu_decode_stage_pkg::*;

    dec_ctrl_t   ctrl_d;
    dec_ctrl_t   ctrl_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic        accept;

    prv32_inst_decode #(
        .FLAG_ILLEG(FLAG_ILLEG)
    ) u_dec (
        .inst_i (in_inst),
        .ctrl_o (ctrl_d)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= RESET_PC;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                ctrl_q <= ctrl_d;
                pc_q   <= in_pc;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_alufn   = ctrl_q.alufn;
    assign out_itype   = ctrl_q.itype;
    assign out_shamt   = ctrl_q.shamt;
    assign out_imm     = ctrl_q.imm;
    assign out_a_pc    = ctrl_q.a_pc;
    assign out_b_imm   = ctrl_q.b_imm;
    assign out_rs1     = ctrl_q.rs1;
    assign out_rs2     = ctrl_q.rs2;
    assign out_rd      = ctrl_q.rd;
    assign out_reg_wr  = ctrl_q.reg_wr;
    assign out_branch  = ctrl_q.branch;
    assign out_funct3  = ctrl_q.funct3;
    assign out_pc      = pc_q;
    assign out_illegal = ctrl_q.illegal;

endmodule
